fg_cordic_pipe: RTL and testbench

- Parametrised, fully pipelined CORDIC engine for the function generator. Successor to the fixed 8-bit rotation-only core.
- Supports per-sample selection of rotation mode (sine/cosine generation) or vectoring mode (magnitude/phase extraction).
- Carries a valid flag and a channel tag through the pipeline so several generator channels can time-share one engine.
- Sits between the phase accumulators / channel mux and the output scaling/DAC stage.

---
 rtl/fg_cordic_pkg.sv | 28 ++
 rtl/fg_cordic_stage.sv | 70 +++++++
 rtl/fg_cordic_pipe.sv | 136 +++++++++++++
 tb/tb_fg_cordic_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_cordic_pkg.sv
// Shared constants for the pipelined CORDIC: mode encodings and the arctangent table.
package fg_cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam int unsigned ATAN_ENTRIES = 16;

    // atan(2^-i) with 45 degrees = 8192 (full circle = 2^16)
    localparam int unsigned ATAN_Q16 [0:ATAN_ENTRIES-1] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
        41, 20, 10, 5, 3, 1, 1, 0
    };

    // Rounded arctangent entry rescaled to a p-bit full circle
    function automatic int unsigned atan_scaled(input int unsigned p, input int unsigned idx);
        int unsigned v;
        if (idx >= ATAN_ENTRIES) begin
            return 0;
        end
        v = ATAN_Q16[idx];
        if (p >= 16) begin
            return v;
        end
        return (v + (32'd1 << (15 - p))) >> (16 - p);
    endfunction

endpackage

// File: rtl/fg_cordic_stage.sv
// One CORDIC micro-rotation register stage; the shift and angle step are fixed by IDX.
module fg_cordic_stage
    import fg_cordic_pkg::*;
#(
    parameter int unsigned W     = 10,
    parameter int unsigned P     = 10,
    parameter int unsigned TAG_W = 2,
    parameter int unsigned IDX   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 valid_d,
    input  logic                 mode_d,
    input  logic [TAG_W-1:0]     tag_d,
    input  logic signed [W-1:0]  x_d,
    input  logic signed [W-1:0]  y_d,
    input  logic signed [P-1:0]  phase_d,
    output logic                 valid_q,
    output logic                 mode_q,
    output logic [TAG_W-1:0]     tag_q,
    output logic signed [W-1:0]  x_q,
    output logic signed [W-1:0]  y_q,
    output logic signed [P-1:0]  phase_q
);

    localparam logic signed [P-1:0] ATAN = P'(atan_scaled(P, IDX));

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic                dir_pos;
    logic signed [W-1:0] x_nx;
    logic signed [W-1:0] y_nx;
    logic signed [P-1:0] phase_nx;

    // Direction follows the residual angle (rotation) or the sign of y (vectoring)
    always_comb begin
        x_sh     = x_d >>> IDX;
        y_sh     = y_d >>> IDX;
        dir_pos  = (mode_d == MODE_ROT) ? ~phase_d[P-1] : y_d[W-1];
        x_nx     = x_d + y_sh;
        y_nx     = y_d - x_sh;
        phase_nx = phase_d + ATAN;
        if (dir_pos) begin
            x_nx     = x_d - y_sh;
            y_nx     = y_d + x_sh;
            phase_nx = phase_d - ATAN;
        end
    end

    // Stage register; holds while the pipeline is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            tag_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= '0;
        end else if (clk_en) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            x_q     <= x_nx;
            y_q     <= y_nx;
            phase_q <= phase_nx;
        end
    end

endmodule

// File: rtl/fg_cordic_pipe.sv
// Fully pipelined rotation/vectoring CORDIC with valid and channel tag carried alongside.
module fg_cordic_pipe
    import fg_cordic_pkg::*;
#(
    parameter int unsigned BITWIDTH       = 8,
    parameter int unsigned BITWIDTH_PHASE = 10,
    parameter int unsigned ITERATIONS     = 7,
    parameter int unsigned TAG_W          = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clk_en_i,
    input  logic                               valid_i,
    input  logic                               mode_i,
    input  logic [TAG_W-1:0]                   tag_i,
    input  logic signed [BITWIDTH_PHASE-1:0]   phase_i,
    input  logic signed [BITWIDTH-1:0]         x_i,
    input  logic signed [BITWIDTH-1:0]         y_i,
    output logic                               valid_o,
    output logic                               mode_o,
    output logic [TAG_W-1:0]                   tag_o,
    output logic signed [BITWIDTH+1:0]         x_o,
    output logic signed [BITWIDTH+1:0]         y_o,
    output logic signed [BITWIDTH_PHASE-1:0]   phase_o
);

    localparam int unsigned W = BITWIDTH + 2;
    localparam int unsigned P = BITWIDTH_PHASE;
    localparam logic signed [P-1:0] QUARTER = P'(2 ** (P - 2));

    // Index 0 is the pre-rotation stage, index k+1 the output of micro-stage k
    logic                valid_s [0:ITERATIONS];
    logic                mode_s  [0:ITERATIONS];
    logic [TAG_W-1:0]    tag_s   [0:ITERATIONS];
    logic signed [W-1:0] x_s     [0:ITERATIONS];
    logic signed [W-1:0] y_s     [0:ITERATIONS];
    logic signed [P-1:0] phase_s [0:ITERATIONS];

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] y_ext;
    logic signed [W-1:0] pre_x;
    logic signed [W-1:0] pre_y;
    logic signed [P-1:0] pre_phase;

    // Quadrant pre-rotation brings the problem into +/-90 degrees; widening first makes negation safe
    always_comb begin
        x_ext     = W'(x_i);
        y_ext     = W'(y_i);
        pre_x     = x_ext;
        pre_y     = y_ext;
        pre_phase = phase_i;
        if (mode_i == MODE_ROT) begin
            case (phase_i[P-1 -: 2])
                2'b01: begin
                    pre_x     = -y_ext;
                    pre_y     = x_ext;
                    pre_phase = {2'b00, phase_i[P-3:0]};
                end
                2'b10: begin
                    pre_x     = y_ext;
                    pre_y     = -x_ext;
                    pre_phase = {2'b11, phase_i[P-3:0]};
                end
                default: begin
                    pre_phase = phase_i;
                end
            endcase
        end else begin
            pre_phase = '0;
            if (x_i[BITWIDTH-1]) begin
                if (!y_i[BITWIDTH-1]) begin
                    pre_x     = y_ext;
                    pre_y     = -x_ext;
                    pre_phase = QUARTER;
                end else begin
                    pre_x     = -y_ext;
                    pre_y     = x_ext;
                    pre_phase = -QUARTER;
                end
            end
        end
    end

    // Pre-rotation stage register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_s[0] <= 1'b0;
            mode_s[0]  <= 1'b0;
            tag_s[0]   <= '0;
            x_s[0]     <= '0;
            y_s[0]     <= '0;
            phase_s[0] <= '0;
        end else if (clk_en_i) begin
            valid_s[0] <= valid_i;
            mode_s[0]  <= mode_i;
            tag_s[0]   <= tag_i;
            x_s[0]     <= pre_x;
            y_s[0]     <= pre_y;
            phase_s[0] <= pre_phase;
        end
    end

    // Micro-rotation chain
    for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
        fg_cordic_stage #(
            .W     (W),
            .P     (P),
            .TAG_W (TAG_W),
            .IDX   (k)
        ) u_stage (
            .clk     (clk_i),
            .rst     (rst_i),
            .clk_en  (clk_en_i),
            .valid_d (valid_s[k]),
            .mode_d  (mode_s[k]),
            .tag_d   (tag_s[k]),
            .x_d     (x_s[k]),
            .y_d     (y_s[k]),
            .phase_d (phase_s[k]),
            .valid_q (valid_s[k+1]),
            .mode_q  (mode_s[k+1]),
            .tag_q   (tag_s[k+1]),
            .x_q     (x_s[k+1]),
            .y_q     (y_s[k+1]),
            .phase_q (phase_s[k+1])
        );
    end

    assign valid_o = valid_s[ITERATIONS];
    assign mode_o  = mode_s[ITERATIONS];
    assign tag_o   = tag_s[ITERATIONS];
    assign x_o     = x_s[ITERATIONS];
    assign y_o     = y_s[ITERATIONS];
    assign phase_o = phase_s[ITERATIONS];

endmodule

// File: tb/tb_fg_cordic_pipe.sv
// Directed bench for fg_cordic_pipe at default parameters (8-bit data, 10-bit phase, 7 stages).
module tb_fg_cordic_pipe;

    logic              clk_i;
    logic              rst_i;
    logic              clk_en_i;
    logic              valid_i;
    logic              mode_i;
    logic [1:0]        tag_i;
    logic signed [9:0] phase_i;
    logic signed [7:0] x_i;
    logic signed [7:0] y_i;
    logic              valid_o;
    logic              mode_o;
    logic [1:0]        tag_o;
    logic signed [9:0] x_o;
    logic signed [9:0] y_o;
    logic signed [9:0] phase_o;

    int checks = 0;
    int errors = 0;

    // Vectors: A rot 0deg, B rot 135deg, C vec (0,100), D vec (-100,-1), E rot -135deg
    int vm  [5] = '{0, 0, 1, 1, 0};
    int vph [5] = '{0, 384, 0, 0, -384};
    int vx  [5] = '{77, 77, 0, -100, 77};
    int vy  [5] = '{0, 0, 100, -1, 0};
    // Hand-iterated results (truncating shifts, 10-bit wrapping phase)
    int ex  [5] = '{126, -90, 165, 167, -93};
    int ey  [5] = '{1, 93, 0, 1, -86};
    int eph [5] = '{0, 2, 256, -512, 2};

    fg_cordic_pipe dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clk_en_i (clk_en_i),
        .valid_i  (valid_i),
        .mode_i   (mode_i),
        .tag_i    (tag_i),
        .phase_i  (phase_i),
        .x_i      (x_i),
        .y_i      (y_i),
        .valid_o  (valid_o),
        .mode_o   (mode_o),
        .tag_o    (tag_o),
        .x_o      (x_o),
        .y_o      (y_o),
        .phase_o  (phase_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_vec(input int idx, input logic [1:0] tag);
        valid_i = 1'b1;
        mode_i  = 1'(vm[idx]);
        tag_i   = tag;
        phase_i = 10'(vph[idx]);
        x_i     = 8'(vx[idx]);
        y_i     = 8'(vy[idx]);
    endtask

    task automatic drive_idle();
        valid_i = 1'b0;
        mode_i  = 1'b0;
        tag_i   = 2'd0;
        phase_i = '0;
        x_i     = '0;
        y_i     = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid_o !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        clk_en_i = 1'b1;
        drive_idle();
        tick();
        tick();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++;
        if (mode_o !== 1'b0 || tag_o !== 2'd0) begin errors++; $display("FAIL reset_mode_tag: got %b/%0d expected 0/0", mode_o, tag_o); end
        checks++;
        if (x_o !== 10'd0 || y_o !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d/%0d expected 0/0", x_o, y_o); end
        checks++;
        if (phase_o !== 10'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase_o); end
        #2 rst_i = 1'b0;
        tick();
    endtask

    task automatic test_rotation();
        int list [3] = '{0, 1, 4};
        int n;
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = list[k];
            drive_vec(idx, 2'(k + 1));
            tick();
            drive_idle();
            wait_valid(n);
            checks++;
            if (n + 1 != 8) begin errors++; $display("FAIL rot_latency[%0d]: got %0d expected 8", idx, n + 1); end
            checks++;
            if (x_o !== 10'(ex[idx]) || y_o !== 10'(ey[idx])) begin
                errors++; $display("FAIL rot_xy[%0d]: got %0d/%0d expected %0d/%0d", idx, x_o, y_o, ex[idx], ey[idx]);
            end
            checks++;
            if (phase_o !== 10'(eph[idx])) begin errors++; $display("FAIL rot_phase[%0d]: got %0d expected %0d", idx, phase_o, eph[idx]); end
            checks++;
            if (tag_o !== 2'(k + 1) || mode_o !== 1'b0) begin
                errors++; $display("FAIL rot_tag_mode[%0d]: got %0d/%b expected %0d/0", idx, tag_o, mode_o, k + 1);
            end
            tick();
            checks++;
            if (valid_o !== 1'b0) begin errors++; $display("FAIL rot_single_pulse[%0d]: got %b expected 0", idx, valid_o); end
        end
    endtask

    task automatic test_vectoring();
        int n;
        for (int idx = 2; idx <= 3; idx++) begin
            drive_vec(idx, 2'(idx));
            tick();
            drive_idle();
            wait_valid(n);
            checks++;
            if (n + 1 != 8) begin errors++; $display("FAIL vec_latency[%0d]: got %0d expected 8", idx, n + 1); end
            checks++;
            if (x_o !== 10'(ex[idx]) || y_o !== 10'(ey[idx])) begin
                errors++; $display("FAIL vec_xy[%0d]: got %0d/%0d expected %0d/%0d", idx, x_o, y_o, ex[idx], ey[idx]);
            end
            checks++;
            if (phase_o !== 10'(eph[idx])) begin errors++; $display("FAIL vec_phase[%0d]: got %0d expected %0d", idx, phase_o, eph[idx]); end
            checks++;
            if (tag_o !== 2'(idx) || mode_o !== 1'b1) begin
                errors++; $display("FAIL vec_tag_mode[%0d]: got %0d/%b expected %0d/1", idx, tag_o, mode_o, idx);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int order [4] = '{0, 2, 1, 3};
        int n;
        int idx;
        for (int k = 0; k < 4; k++) begin
            drive_vec(order[k], 2'(k));
            tick();
        end
        drive_idle();
        wait_valid(n);
        checks++;
        if (n + 4 != 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", n + 4); end
        for (int k = 0; k < 4; k++) begin
            idx = order[k];
            checks++;
            if (valid_o !== 1'b1 || tag_o !== 2'(k) || mode_o !== 1'(vm[idx])) begin
                errors++; $display("FAIL b2b_ctrl[%0d]: got v%b t%0d m%b expected v1 t%0d m%0d", k, valid_o, tag_o, mode_o, k, vm[idx]);
            end
            checks++;
            if (x_o !== 10'(ex[idx]) || y_o !== 10'(ey[idx]) || phase_o !== 10'(eph[idx])) begin
                errors++; $display("FAIL b2b_data[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   k, x_o, y_o, phase_o, ex[idx], ey[idx], eph[idx]);
            end
            tick();
        end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b expected 0", valid_o); end
    endtask

    task automatic test_clk_en();
        int n;
        int extra;
        drive_vec(0, 2'd1);
        tick();
        drive_idle();
        tick();
        drive_vec(2, 2'd2);
        tick();
        drive_idle();
        wait_valid(n);
        checks++;
        if (n + 3 != 8) begin errors++; $display("FAIL stall_pre_latency: got %0d expected 8", n + 3); end
        checks++;
        if (tag_o !== 2'd1 || x_o !== 10'sd126) begin errors++; $display("FAIL stall_first: got t%0d x%0d expected t1 x126", tag_o, x_o); end
        clk_en_i = 1'b0;
        drive_vec(3, 2'd3);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || tag_o !== 2'd1 || x_o !== 10'sd126 || y_o !== 10'sd1) begin
                errors++; $display("FAIL stall_hold[%0d]: got v%b t%0d x%0d y%0d expected v1 t1 x126 y1", c, valid_o, tag_o, x_o, y_o);
            end
        end
        clk_en_i = 1'b1;
        drive_idle();
        tick();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_bubble: got %b expected 0", valid_o); end
        tick();
        checks++;
        if (valid_o !== 1'b1 || tag_o !== 2'd2 || x_o !== 10'sd165 || phase_o !== 10'sd256) begin
            errors++; $display("FAIL stall_second: got v%b t%0d x%0d p%0d expected v1 t2 x165 p256", valid_o, tag_o, x_o, phase_o);
        end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_o === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL stall_no_dup: got %0d extra outputs expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int n;
        int extra;
        for (int k = 0; k < 4; k++) begin
            drive_vec(k, 2'(k));
            tick();
        end
        drive_idle();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (valid_o !== 1'b1 || tag_o !== 2'd0) begin errors++; $display("FAIL rstmid_pre: got v%b t%0d expected v1 t0", valid_o, tag_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_async_valid: got %b expected 0", valid_o); end
        checks++;
        if (x_o !== 10'd0 || y_o !== 10'd0 || phase_o !== 10'd0 || tag_o !== 2'd0 || mode_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_data: got x%0d y%0d p%0d t%0d m%b expected zeros", x_o, y_o, phase_o, tag_o, mode_o);
        end
        tick();
        tick();
        #2 rst_i = 1'b0;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_o === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL rstmid_discard: got %0d outputs expected 0", extra); end
        drive_vec(0, 2'd3);
        tick();
        drive_idle();
        wait_valid(n);
        checks++;
        if (n + 1 != 8 || x_o !== 10'sd126 || tag_o !== 2'd3) begin
            errors++; $display("FAIL rstmid_recover: got lat%0d x%0d t%0d expected lat8 x126 t3", n + 1, x_o, tag_o);
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        clk_en_i = 1'b1;
        drive_idle();
        test_reset();
        test_rotation();
        test_vectoring();
        test_back_to_back();
        test_clk_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
